// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions used by the fetch stage and its helpers.
package rv_pipe_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) presented when no instruction is valid.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Default PC loaded on reset; must be word aligned.
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

  // Upper bound on requests in flight plus words waiting in the response buffer.
  localparam int FETCH_MAX_OUTSTANDING = 2;

  // Sequential successor of a word-aligned PC, wrapping at 2^32.
  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_resp_fifo.sv
// Two-entry {inst, pc} FIFO with synchronous flush. Used both as the
// instruction response buffer and as the queue of issued fetch addresses.
module fetch_resp_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  input  logic        pop,
  output logic [31:0] head_inst,
  output logic [31:0] head_pc,
  output logic [1:0]  count,
  output logic        empty,
  output logic        full
);

  logic [31:0] inst_mem [2];
  logic [31:0] pc_mem   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps up to two requests in flight to
// an in-order variable-latency instruction memory, buffers returns in a
// 2-entry FIFO and squashes everything in flight on an execute redirect.
//
// Memory handshake: a request transfers on any cycle where o_imem_req and
// i_imem_gnt are both high; o_imem_addr is held until that cycle. Responses
// carry no ready: i_imem_rvalid is a one-cycle pulse per granted request, in
// grant order, never earlier than the cycle after the grant.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus_4
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;

  logic [31:0] resp_head_inst;
  logic [31:0] resp_head_pc;
  logic [1:0]  resp_count;
  logic        resp_empty;
  logic        resp_full;
  logic        resp_push;
  logic        resp_pop;

  logic [31:0] tag_head_pc;
  logic [31:0] tag_inst_unused;
  logic [1:0]  tag_count_unused;
  logic        tag_empty_unused;
  logic        tag_full_unused;

  logic [2:0]  credit_used;
  logic        grant;
  logic        accept;
  logic        fall_through;
  logic [31:0] redirect_target;
  logic [1:0]  redirect_pc_low_unused;

  // Instruction fetch is always word aligned; the low target bits are ignored.
  assign redirect_target        = {i_redirect_pc[31:2], 2'b00};
  assign redirect_pc_low_unused = i_redirect_pc[1:0];

  // Credits cover both in-flight requests and buffered words, so every
  // returning word always has a FIFO slot even while decode is stalled.
  assign credit_used = {1'b0, outstanding} + {1'b0, resp_count};
  assign o_imem_req  = rst && !i_redirect && (credit_used < 3'(FETCH_MAX_OUTSTANDING));
  assign o_imem_addr = pc;
  assign grant       = o_imem_req && i_imem_gnt;

  // A response is kept only when it belongs to the current fetch stream.
  assign accept       = i_imem_rvalid && !i_redirect && (drop_cnt == 2'd0);
  assign fall_through = accept && resp_empty && !i_stall;
  assign resp_push    = accept && !fall_through;
  assign resp_pop     = !i_redirect && !i_stall && !resp_empty;

  fetch_resp_fifo u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_redirect),
    .push      (resp_push),
    .push_inst (i_imem_rdata),
    .push_pc   (tag_head_pc),
    .pop       (resp_pop),
    .head_inst (resp_head_inst),
    .head_pc   (resp_head_pc),
    .count     (resp_count),
    .empty     (resp_empty),
    .full      (resp_full)
  );

  // Addresses of live requests, popped as their words return, so each word
  // is paired with the PC it was fetched from.
  fetch_resp_fifo u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_redirect),
    .push      (grant),
    .push_inst (32'h0000_0000),
    .push_pc   (pc),
    .pop       (accept),
    .head_inst (tag_inst_unused),
    .head_pc   (tag_head_pc),
    .count     (tag_count_unused),
    .empty     (tag_empty_unused),
    .full      (tag_full_unused)
  );

  // PC advance, in-flight count and stale-response tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_ADDR;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, grant} - {1'b0, i_imem_rvalid};
      if (i_redirect) begin
        pc       <= redirect_target;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - {1'b0, i_imem_rvalid};
      end else begin
        if (grant) pc <= pc_add4(pc);
        if (i_imem_rvalid && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  // Output register toward IF/ID: redirect squashes, stall holds, otherwise
  // the buffered head wins over a word arriving this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_inst      <= NOP_INST;
      o_pc        <= 32'h0000_0000;
      o_pc_plus_4 <= 32'h0000_0000;
    end else if (i_redirect) begin
      o_valid <= 1'b0;
      o_inst  <= NOP_INST;
    end else if (!i_stall) begin
      if (!resp_empty) begin
        o_valid     <= 1'b1;
        o_inst      <= resp_head_inst;
        o_pc        <= resp_head_pc;
        o_pc_plus_4 <= pc_add4(resp_head_pc);
      end else if (fall_through) begin
        o_valid     <= 1'b1;
        o_inst      <= i_imem_rdata;
        o_pc        <= tag_head_pc;
        o_pc_plus_4 <= pc_add4(tag_head_pc);
      end else begin
        o_valid <= 1'b0;
        o_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with configurable latency,
// expected-instruction queue and per-cycle output prediction.
module tb_fetch_stage;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;

  fetch_stage #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_valid       (valid),
    .o_inst        (inst),
    .o_pc          (pc),
    .o_pc_plus_4   (pc4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;      // address the DUT drove
    logic [31:0] exp_addr;  // address the bench expected
    int unsigned ready;     // first cycle the response may return
    logic        stale;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [63:0] exp_q[$];    // {pc, inst} in presentation order

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic        mem_rand = 1'b0;
  logic        gnt_rand = 1'b0;

  logic        p_valid = 1'b0;
  logic [31:0] p_inst  = 32'h0000_0013;
  logic [31:0] p_pc    = 32'h0;
  logic [31:0] p_pc4   = 32'h0;
  logic [31:0] exp_fetch_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic s, input logic r, input logic [31:0] tgt, input logic rst_n);
    mem_req_t    h;
    logic        resp;
    logic        exp_req;
    logic [63:0] e;
    @(posedge clk);
    #1;
    check("o_valid", {31'b0, valid}, {31'b0, p_valid});
    check("o_inst", inst, p_inst);
    check("o_pc", pc, p_pc);
    check("o_pc_plus_4", pc4, p_pc4);
    cyc++;
    rst         = rst_n;
    stall       = s;
    redirect    = r;
    redirect_pc = tgt;
    imem_gnt    = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    resp = rst_n && (mem_q.size() > 0) && (mem_q[0].ready <= cyc) &&
           (!mem_rand || ($urandom_range(0, 2) != 0));
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(mem_q[0].addr) : $urandom();
    #1;
    exp_req = rst_n && !r && ((mem_q.size() + exp_q.size()) < 2);
    check("o_imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (dut.resp_push && !dut.resp_pop)
      check("resp_fifo_overflow", {31'b0, dut.resp_full}, 32'd0);
    if (resp) begin
      h = mem_q.pop_front();
      if (!h.stale && !r) exp_q.push_back({h.exp_addr, mem_word(h.exp_addr)});
    end
    if (imem_req && imem_gnt) begin
      check("o_imem_addr", imem_addr, exp_fetch_pc);
      mem_q.push_back('{addr: imem_addr, exp_addr: exp_fetch_pc,
                        ready: cyc + $urandom_range(lat_min, lat_max), stale: 1'b0});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (!rst_n) begin
      mem_q.delete();
      exp_q.delete();
      p_valid = 1'b0; p_inst = NOP_INST; p_pc = 32'h0; p_pc4 = 32'h0;
      exp_fetch_pc = 32'h0;
    end else if (r) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      p_valid = 1'b0; p_inst = NOP_INST;
      exp_fetch_pc = {tgt[31:2], 2'b00};
    end else if (!s) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        p_valid = 1'b1; p_pc = e[63:32]; p_inst = e[31:0]; p_pc4 = e[63:32] + 32'd4;
      end else begin
        p_valid = 1'b0; p_inst = NOP_INST;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic ok;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming with 1-cycle memory, no stalls.
    repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Decode stall while responses keep arriving.
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect to an unaligned target with two requests in flight.
    lat_min = 3; lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (mem_q.size() == 2) ok = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    if (!ok) check("wait_two_outstanding", {31'b0, ok}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as a response.
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (mem_q.size() > 0 && mem_q[0].ready <= cyc + 1) ok = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    if (!ok) check("wait_resp_due", {31'b0, ok}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while decode is stalled.
    step(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset with credits exhausted and data buffered.
    lat_min = 2; lat_max = 2;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (exp_q.size() >= 1 && (mem_q.size() + exp_q.size()) == 2) ok = 1'b1;
      else step(1'b1, 1'b0, 32'h0, 1'b1);
    end
    if (!ok) check("wait_credits_full", {31'b0, ok}, 32'd1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Random mix of stalls, redirects, grant gaps, latency and resets.
    lat_min = 1; lat_max = 4;
    mem_rand = 1'b1; gnt_rand = 1'b1;
    repeat (400)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom(),
           $urandom_range(0, 63) != 0);
    mem_rand = 1'b0; gnt_rand = 1'b0;
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
